// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// fetch_stage_pkg - shared types and defaults for the instruction fetch stage
// Rev 1.0
// ============================================================================
package fetch_stage_pkg;

    typedef logic [31:0] instruction_t;

    typedef struct packed {
        logic [31:0]  pc;
        instruction_t instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0001_0000;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if - icache request/response, redirect and decode handshake bundle
// Rev 1.0
// ============================================================================
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic         icache_req_valid_o;
    logic [31:0]  icache_req_addr_o;
    logic         icache_req_ready_i;
    logic         icache_rsp_valid_i;
    logic [31:0]  icache_rsp_data_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         instr_valid_o;
    logic         instr_ready_i;
    instruction_t instr_o;
    logic [31:0]  pc_o;

    modport master (
        output icache_req_valid_o, icache_req_addr_o,
        input  icache_req_ready_i, icache_rsp_valid_i, icache_rsp_data_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  icache_req_valid_o, icache_req_addr_o,
        output icache_req_ready_i, icache_rsp_valid_i, icache_rsp_data_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, pc_o,
        output instr_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo - synchronous FIFO of fetch entries with flush; push+pop when full is legal
// Rev 1.0
// ============================================================================
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  wire logic          clk_i,
    input  wire logic          reset_ni,
    input  wire logic          push_i,
    input  wire fetch_entry_t  entry_i,
    input  wire logic          pop_i,
    input  wire logic          flush_i,
    output fetch_entry_t       entry_o,
    output logic [CW-1:0]      count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign entry_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_ni && do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage - owns the PC, issues in-order icache requests, buffers results for decode
// Rev 1.0
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  wire logic clk_i,
    input  wire logic reset_ni,
    fetch_stage_if.master bus
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    logic [31:0]   pc_q,    pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q,  drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head_entry;
    fetch_entry_t  push_entry;

    logic [CW1-1:0] credits_used;
    logic           req_valid;
    logic           req_fire;
    logic           rsp;
    logic           rsp_drop;
    logic [31:0]    rsp_pc;
    logic           push;
    logic           pop;

    // Outstanding requests plus buffered entries never exceed the FIFO size,
    // so every non-dropped response is guaranteed a slot.
    assign credits_used = {1'b0, outst_q} + {1'b0, fifo_count};
    assign req_valid    = !bus.redirect_i && (credits_used < CW1'(FIFO_DEPTH));
    assign req_fire     = req_valid && bus.icache_req_ready_i;

    assign rsp      = bus.icache_rsp_valid_i;
    assign rsp_drop = rsp && (drop_q != '0);

    // With no wrong-path responses pending, in-flight requests are the
    // contiguous words just below pc_q; the oldest is the one returning.
    assign rsp_pc     = pc_q - (32'(outst_q) << 2);
    assign push_entry = '{pc: rsp_pc, instr: bus.icache_rsp_data_i};
    assign push       = rsp && !rsp_drop && !bus.redirect_i;
    assign pop        = !fifo_empty && bus.instr_ready_i && !bus.redirect_i;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + CW'(req_fire) - CW'(rsp);
        drop_d  = drop_q;
        if (bus.redirect_i) begin
            pc_d   = word_align(bus.redirect_pc_i);
            drop_d = outst_d;
        end else begin
            if (req_fire) pc_d   = pc_q + 32'd4;
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .entry_i  (push_entry),
        .pop_i    (pop),
        .flush_i  (bus.redirect_i),
        .entry_o  (head_entry),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign bus.icache_req_valid_o = req_valid;
    assign bus.icache_req_addr_o  = pc_q;
    assign bus.instr_valid_o      = !fifo_empty;
    assign bus.instr_o            = head_entry.instr;
    assign bus.pc_o               = head_entry.pc;

    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            assert (drop_q <= outst_q);
            assert (!(rsp && (outst_q == '0)));
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage - directed bench with a queue-level fetch/icache model
// Rev 1.0
// ============================================================================
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0001_0000;
    localparam int          DEPTH  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] pc;
        bit          wrong;
        int          due;
    } infl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    infl_t       inflq[$];
    ent_t        outq[$];
    logic [31:0] m_pc;

    int          cyc;
    int          n_chk;
    int          n_fail;
    int          lat;
    logic        t_redir, t_rdy, t_qrdy;
    logic [31:0] t_rpc;

    logic [31:0] acc_log[$];
    logic [31:0] dpc_log[$];
    logic [31:0] dins_log[$];
    int          first_acc_cyc, first_val_cyc;
    logic        s_req_valid, s_instr_valid;
    logic [31:0] s_addr;

    function automatic logic [31:0] ic_data(input logic [31:0] a);
        return a ^ 32'hC3A5_0F0F;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        dpc_log.delete();
        dins_log.delete();
        first_acc_cyc = -1;
        first_val_cyc = -1;
    endtask

    task automatic tick();
        bit    rsp_v;
        bit    exp_rv;
        bit    fire;
        ent_t  e;
        infl_t f;
        rsp_v = rst_n && (inflq.size() > 0) && (inflq[0].due <= cyc);
        bus.redirect_i         = t_redir;
        bus.redirect_pc_i      = t_rpc;
        bus.instr_ready_i      = t_rdy;
        bus.icache_req_ready_i = t_qrdy;
        bus.icache_rsp_valid_i = rsp_v;
        bus.icache_rsp_data_i  = rsp_v ? ic_data(inflq[0].pc) : 32'hDEAD_BEEF;
        @(negedge clk);
        s_req_valid   = bus.icache_req_valid_o;
        s_instr_valid = bus.instr_valid_o;
        s_addr        = bus.icache_req_addr_o;
        if (!rst_n) begin
            inflq.delete();
            outq.delete();
            m_pc = RST_PC;
        end else begin
            exp_rv = !t_redir && ((inflq.size() + outq.size()) < DEPTH);
            chk("req_valid",   32'(bus.icache_req_valid_o), 32'(exp_rv));
            chk("req_addr",    bus.icache_req_addr_o, m_pc);
            chk("instr_valid", 32'(bus.instr_valid_o), 32'(outq.size() > 0));
            if (outq.size() > 0) begin
                chk("instr", bus.instr_o, outq[0].instr);
                chk("pc",    bus.pc_o,    outq[0].pc);
            end
            if (bus.icache_req_valid_o && t_qrdy) begin
                acc_log.push_back(bus.icache_req_addr_o);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (bus.instr_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
            if (bus.instr_valid_o && t_rdy && !t_redir) begin
                dpc_log.push_back(bus.pc_o);
                dins_log.push_back(bus.instr_o);
            end
            fire = exp_rv && t_qrdy;
            if (outq.size() > 0 && t_rdy && !t_redir) e = outq.pop_front();
            if (rsp_v) begin
                f = inflq.pop_front();
                if (!f.wrong && !t_redir) begin
                    e.pc    = f.pc;
                    e.instr = ic_data(f.pc);
                    outq.push_back(e);
                end
            end
            if (t_redir) begin
                outq.delete();
                foreach (inflq[i]) inflq[i].wrong = 1'b1;
                m_pc = t_rpc & ~32'd3;
            end
            if (fire) begin
                f.pc    = m_pc;
                f.wrong = 1'b0;
                f.due   = cyc + lat;
                inflq.push_back(f);
                m_pc    = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        t_redir = 1'b0;
        run(2);
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        int bad;
        bit found;
        n_chk = 0; n_fail = 0; cyc = 0; lat = 1;
        rst_n = 1'b0; t_redir = 1'b0; t_rdy = 1'b1; t_qrdy = 1'b1; t_rpc = '0;
        m_pc = RST_PC;
        clear_logs();
        @(posedge clk);
        #1;

        // 1: streaming fetch from reset, 1-cycle icache
        do_reset();
        t_qrdy = 1'b1; t_rdy = 1'b1; lat = 1;
        run(12);
        chk("t1_acc0", qat(acc_log, 0), 32'h0001_0000);
        chk("t1_acc1", qat(acc_log, 1), 32'h0001_0004);
        chk("t1_acc2", qat(acc_log, 2), 32'h0001_0008);
        chk("t1_pc0",  qat(dpc_log, 0), 32'h0001_0000);
        chk("t1_pc1",  qat(dpc_log, 1), 32'h0001_0004);
        chk("t1_pc2",  qat(dpc_log, 2), 32'h0001_0008);
        chk("t1_ins0", qat(dins_log, 0), 32'hC3A4_0F0F);
        chk("t1_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);

        // 2: decode stalls, credit limit, then drains without loss
        t_rdy = 1'b0;
        run(10);
        chk("t2_req_blocked", 32'(s_req_valid), 32'd0);
        chk("t2_fifo_valid",  32'(s_instr_valid), 32'd1);
        t_rdy = 1'b1;
        run(10);
        bad = 0;
        for (int i = 1; i < dpc_log.size(); i++)
            if (dpc_log[i] !== dpc_log[i-1] + 32'd4) bad++;
        chk("t2_sequence_gaps", 32'(bad), 32'd0);
        chk("t2_enough_delivered", 32'(dpc_log.size() >= 12), 32'd1);

        // 3: icache not ready, address held
        do_reset();
        t_qrdy = 1'b0;
        run(5);
        chk("t3_addr_held",  s_addr, 32'h0001_0000);
        chk("t3_valid_held", 32'(s_req_valid), 32'd1);
        chk("t3_no_accept",  32'(acc_log.size()), 32'd0);
        t_qrdy = 1'b1;
        run(1);
        t_qrdy = 1'b0;
        chk("t3_one_accept", 32'(acc_log.size()), 32'd1);
        chk("t3_accept_addr", qat(acc_log, 0), 32'h0001_0000);
        run(3);
        t_qrdy = 1'b1;

        // 4: two in flight, redirect to unaligned target
        do_reset();
        lat = 3; t_qrdy = 1'b1; t_rdy = 1'b1;
        run(2);
        chk("t4_two_inflight", 32'(acc_log.size()), 32'd2);
        clear_logs();
        t_redir = 1'b1; t_rpc = 32'h0000_2002;
        tick();
        chk("t4_no_req_on_redirect", 32'(s_req_valid), 32'd0);
        t_redir = 1'b0;
        run(12);
        chk("t4_acc0", qat(acc_log, 0), 32'h0000_2000);
        chk("t4_pc0",  qat(dpc_log, 0), 32'h0000_2000);
        chk("t4_ins0", qat(dins_log, 0), 32'hC3A5_2F0F);

        // 5: redirect coincides with response and pop
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inflq.size() > 0 && inflq[0].due <= cyc && outq.size() > 0) found = 1'b1;
            else tick();
        end
        chk("t5_setup_found", 32'(found), 32'd1);
        t_redir = 1'b1; t_rpc = 32'h0000_5000;
        tick();
        chk("t5_no_req", 32'(s_req_valid), 32'd0);
        t_redir = 1'b0;
        tick();
        chk("t5_fifo_empty", 32'(s_instr_valid), 32'd0);
        run(6);

        // back-to-back redirects: last wins
        clear_logs();
        t_redir = 1'b1; t_rpc = 32'h0000_3000;
        tick();
        t_rpc = 32'h0000_4008;
        tick();
        t_redir = 1'b0;
        run(10);
        chk("b2b_acc0", qat(acc_log, 0), 32'h0000_4008);
        chk("b2b_pc0",  qat(dpc_log, 0), 32'h0000_4008);

        // PC wrap
        clear_logs();
        t_redir = 1'b1; t_rpc = 32'hFFFF_FFF9;
        tick();
        t_redir = 1'b0;
        run(12);
        chk("wrap_pc0", qat(dpc_log, 0), 32'hFFFF_FFF8);
        chk("wrap_pc1", qat(dpc_log, 1), 32'hFFFF_FFFC);
        chk("wrap_pc2", qat(dpc_log, 2), 32'h0000_0000);

        // 6: reset with a full FIFO
        t_rdy = 1'b0;
        run(6);
        chk("t6_fifo_valid", 32'(s_instr_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_valid_cleared", 32'(s_instr_valid), 32'd0);
        chk("t6_addr_reset",    s_addr, RST_PC);
        t_rdy = 1'b1;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
